// File: rtl/hazard_fwd_unit.sv
// Operand forwarding and load-use/branch hazard control for the pipelined core.
// Chooses bypass sources, holds load-use stalls for LOAD_LAT cycles and counts stall cycles.
module hazard_fwd_unit #(
    parameter int REG_W    = 4,
    parameter int NSRC     = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NSRC*REG_W-1:0] id_src,
    input  logic [NSRC-1:0]       id_src_use,
    input  logic [NSRC*REG_W-1:0] ex_src,
    input  logic [REG_W-1:0]      ex_rd,
    input  logic                  ex_rw,
    input  logic                  ex_load,
    input  logic [REG_W-1:0]      mem_rd,
    input  logic                  mem_rw,
    input  logic [REG_W-1:0]      wb_rd,
    input  logic                  wb_rw,
    input  logic                  br_taken,
    output logic [2*NSRC-1:0]     fwd_sel,
    output logic                  stall,
    output logic                  flush,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam int REM_W = $clog2(LOAD_LAT) + 1;

    localparam logic [1:0]       SEL_RF    = 2'b00;
    localparam logic [1:0]       SEL_EXMEM = 2'b10;
    localparam logic [1:0]       SEL_MEMWB = 2'b01;
    localparam logic [REM_W-1:0] REM_ZERO  = {REM_W{1'b0}};
    localparam logic [REM_W-1:0] REM_ONE   = {{(REM_W-1){1'b0}}, 1'b1};
    localparam logic [REM_W-1:0] REM_START = REM_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [2*NSRC-1:0] fwd_sel_s;
    logic [NSRC-1:0]   use_hit_s;
    logic              load_use_s;
    logic              stall_s;

    // A producer index matches a consumer only if it is a real (non-zero) register.
    function automatic logic reg_match(input logic [REG_W-1:0] prod, input logic [REG_W-1:0] cons);
        return (prod != {REG_W{1'b0}}) && (prod == cons);
    endfunction

    // Per-operand bypass select; the younger EX/MEM result shadows MEM/WB.
    always_comb begin
        fwd_sel_s = {(2*NSRC){1'b0}};
        for (int i = 0; i < NSRC; i++) begin
            if (rst) begin
                fwd_sel_s[2*i +: 2] = SEL_RF;
            end else if (mem_rw && reg_match(mem_rd, ex_src[i*REG_W +: REG_W])) begin
                fwd_sel_s[2*i +: 2] = SEL_EXMEM;
            end else if (wb_rw && reg_match(wb_rd, ex_src[i*REG_W +: REG_W])) begin
                fwd_sel_s[2*i +: 2] = SEL_MEMWB;
            end else begin
                fwd_sel_s[2*i +: 2] = SEL_RF;
            end
        end
    end

    // Load-use detection: a load in EX whose destination is read by the ID instruction.
    always_comb begin
        use_hit_s = {NSRC{1'b0}};
        for (int i = 0; i < NSRC; i++) begin
            use_hit_s[i] = id_src_use[i] && (id_src[i*REG_W +: REG_W] == ex_rd);
        end
        load_use_s = ex_load && ex_rw && (ex_rd != {REG_W{1'b0}}) && (|use_hit_s);
    end

    // Stall sequencer: first hazard cycle is combinational, the rest come from HOLD.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        stall_s = 1'b0;
        if (rst) begin
            state_d = ST_RUN;
            rem_d   = REM_ZERO;
        end else if (br_taken) begin
            // The dependent instruction is squashed, so any pending hazard is void.
            state_d = ST_RUN;
            rem_d   = REM_ZERO;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (load_use_s) begin
                        stall_s = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = ST_HOLD;
                            rem_d   = REM_START;
                        end else begin
                            state_d = ST_RUN;
                            rem_d   = REM_ZERO;
                        end
                    end else begin
                        stall_s = 1'b0;
                    end
                end
                ST_HOLD: begin
                    stall_s = 1'b1;
                    if (rem_q <= REM_ONE) begin
                        state_d = ST_RUN;
                        rem_d   = REM_ZERO;
                    end else begin
                        rem_d = rem_q - REM_ONE;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    rem_d   = REM_ZERO;
                end
            endcase
        end
    end

    // Saturating performance counter of stall cycles.
    always_comb begin
        if (stall_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, remaining-cycle and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            rem_q       <= REM_ZERO;
            stall_cnt_q <= CNT_ZERO;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_sel   = fwd_sel_s;
    assign stall     = stall_s;
    assign flush     = br_taken && !rst;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench: three parameterisations share stimulus and are checked against
// a cycle-count reference model of the forwarding and stall rules.
module tb_hazard_fwd_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] id_src;
    logic [1:0] id_src_use;
    logic [7:0] ex_src;
    logic [3:0] ex_rd;
    logic       ex_rw, ex_load;
    logic [3:0] mem_rd;
    logic       mem_rw;
    logic [3:0] wb_rd;
    logic       wb_rw;
    logic       br_taken;

    logic [3:0]  fwd_a, fwd_b, fwd_c;
    logic        stall_a, stall_b, stall_c;
    logic        flush_a, flush_b, flush_c;
    logic [15:0] cnt_a, cnt_b;
    logic [1:0]  cnt_c;

    hazard_fwd_unit #(.REG_W(4), .NSRC(2), .LOAD_LAT(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_src(id_src), .id_src_use(id_src_use), .ex_src(ex_src),
        .ex_rd(ex_rd), .ex_rw(ex_rw), .ex_load(ex_load), .mem_rd(mem_rd), .mem_rw(mem_rw),
        .wb_rd(wb_rd), .wb_rw(wb_rw), .br_taken(br_taken),
        .fwd_sel(fwd_a), .stall(stall_a), .flush(flush_a), .stall_cnt(cnt_a));

    hazard_fwd_unit #(.REG_W(4), .NSRC(2), .LOAD_LAT(3), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .id_src(id_src), .id_src_use(id_src_use), .ex_src(ex_src),
        .ex_rd(ex_rd), .ex_rw(ex_rw), .ex_load(ex_load), .mem_rd(mem_rd), .mem_rw(mem_rw),
        .wb_rd(wb_rd), .wb_rw(wb_rw), .br_taken(br_taken),
        .fwd_sel(fwd_b), .stall(stall_b), .flush(flush_b), .stall_cnt(cnt_b));

    hazard_fwd_unit #(.REG_W(4), .NSRC(2), .LOAD_LAT(3), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .id_src(id_src), .id_src_use(id_src_use), .ex_src(ex_src),
        .ex_rd(ex_rd), .ex_rw(ex_rw), .ex_load(ex_load), .mem_rd(mem_rd), .mem_rw(mem_rw),
        .wb_rd(wb_rd), .wb_rw(wb_rw), .br_taken(br_taken),
        .fwd_sel(fwd_c), .stall(stall_c), .flush(flush_c), .stall_cnt(cnt_c));

    typedef struct {
        int         cyc;
        logic [3:0] fwd;
        logic [2:0] stall;
        logic       flush;
        int         cnt0;
        int         cnt1;
        int         cnt2;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    int rem_m [3];
    int cnt_m [3];
    int lat_m [3] = '{1, 3, 3};
    int max_m [3] = '{65535, 65535, 3};

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    // Drive one cycle of inputs, predict the response and queue it for the monitor.
    task automatic drive(input logic r, input logic [7:0] ids, input logic [1:0] usev,
                         input logic [7:0] exs, input logic [3:0] exrd, input logic exrw,
                         input logic exld, input logic [3:0] mrd, input logic mrw,
                         input logic [3:0] wrd, input logic wrw, input logic br);
        exp_t       e;
        bit         hit;
        bit         s;
        logic [3:0] src;
        @(posedge clk);
        #1;
        rst = r; id_src = ids; id_src_use = usev; ex_src = exs; ex_rd = exrd;
        ex_rw = exrw; ex_load = exld; mem_rd = mrd; mem_rw = mrw; wb_rd = wrd;
        wb_rw = wrw; br_taken = br;
        cyc++;
        hit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (exld && exrw && exrd != 4'd0 && usev[i] && ids[i*4 +: 4] == exrd) hit = 1'b1;
        end
        e.cyc   = cyc;
        e.flush = r ? 1'b0 : br;
        e.fwd   = 4'd0;
        for (int i = 0; i < 2; i++) begin
            src = exs[i*4 +: 4];
            if (r)                                     e.fwd[i*2 +: 2] = 2'b00;
            else if (mrw && mrd != 4'd0 && mrd == src) e.fwd[i*2 +: 2] = 2'b10;
            else if (wrw && wrd != 4'd0 && wrd == src) e.fwd[i*2 +: 2] = 2'b01;
            else                                       e.fwd[i*2 +: 2] = 2'b00;
        end
        e.cnt0 = cnt_m[0];
        e.cnt1 = cnt_m[1];
        e.cnt2 = cnt_m[2];
        for (int k = 0; k < 3; k++) begin
            s = !r && !br && (rem_m[k] > 0 || hit);
            e.stall[k] = s;
            if (r) begin
                rem_m[k] = 0;
                cnt_m[k] = 0;
            end else begin
                if (br)              rem_m[k] = 0;
                else if (rem_m[k] > 0) rem_m[k] = rem_m[k] - 1;
                else if (hit)        rem_m[k] = lat_m[k] - 1;
                if (s && cnt_m[k] < max_m[k]) cnt_m[k] = cnt_m[k] + 1;
            end
        end
        sb.push_back(e);
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 2'b00, 8'h00, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    // Load of r5 in EX while the ID instruction reads r5 as operand 1.
    task automatic hazard(input logic [1:0] usev, input logic br);
        drive(1'b0, 8'h50, usev, 8'h00, 4'd5, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, br);
    endtask

    // Monitor: whenever a prediction is pending, compare it with what the DUTs present.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("fwd_a",   e.cyc, 32'(fwd_a),   32'(e.fwd));
            chk("fwd_b",   e.cyc, 32'(fwd_b),   32'(e.fwd));
            chk("fwd_c",   e.cyc, 32'(fwd_c),   32'(e.fwd));
            chk("stall_a", e.cyc, 32'(stall_a), 32'(e.stall[0]));
            chk("stall_b", e.cyc, 32'(stall_b), 32'(e.stall[1]));
            chk("stall_c", e.cyc, 32'(stall_c), 32'(e.stall[2]));
            chk("flush_a", e.cyc, 32'(flush_a), 32'(e.flush));
            chk("flush_b", e.cyc, 32'(flush_b), 32'(e.flush));
            chk("flush_c", e.cyc, 32'(flush_c), 32'(e.flush));
            chk("cnt_a",   e.cyc, 32'(cnt_a),   32'(e.cnt0));
            chk("cnt_b",   e.cyc, 32'(cnt_b),   32'(e.cnt1));
            chk("cnt_c",   e.cyc, 32'(cnt_c),   32'(e.cnt2));
        end
    end

    initial begin
        rst = 1'b1; id_src = 8'h00; id_src_use = 2'b00; ex_src = 8'h00; ex_rd = 4'd0;
        ex_rw = 1'b0; ex_load = 1'b0; mem_rd = 4'd0; mem_rw = 1'b0; wb_rd = 4'd0;
        wb_rw = 1'b0; br_taken = 1'b0;
        repeat (2) @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            rem_m[k] = 0;
            cnt_m[k] = 0;
        end

        // Reset state, including a taken branch and matching producers held under reset.
        drive(1'b1, 8'h00, 2'b00, 8'h33, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 4'd3, 1'b1, 1'b1);
        drive(1'b1, 8'h00, 2'b00, 8'h00, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);

        // Forwarding priority and register-zero cases on both operands.
        drive(1'b0, 8'h00, 2'b00, 8'h03, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 4'd3, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 2'b00, 8'h03, 4'd0, 1'b0, 1'b0, 4'd3, 1'b0, 4'd3, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 2'b00, 8'h00, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 2'b00, 8'h97, 4'd0, 1'b0, 1'b0, 4'd9, 1'b1, 4'd7, 1'b1, 1'b0);

        // Load-use with operand 1 consumed, then unused operands, then load to r0.
        hazard(2'b10, 1'b0);
        repeat (4) idle();
        hazard(2'b00, 1'b0);
        drive(1'b0, 8'h00, 2'b11, 8'h00, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        idle();

        // Branch in the second stall cycle, then a branch coinciding with a hazard.
        hazard(2'b10, 1'b0);
        drive(1'b0, 8'h00, 2'b00, 8'h00, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        repeat (2) idle();
        hazard(2'b10, 1'b1);
        idle();

        // Reset in the middle of a hold.
        hazard(2'b10, 1'b0);
        idle();
        drive(1'b1, 8'h00, 2'b00, 8'h00, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        repeat (2) idle();

        // Enough back-to-back hazards to saturate the narrow counter.
        repeat (5) begin
            hazard(2'b10, 1'b0);
            repeat (3) idle();
        end

        // Randomised traffic over a small register range so matches are frequent.
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                  8'({$urandom_range(0, 3), $urandom_range(0, 3)}) & 8'h33,
                  2'($urandom_range(0, 3)),
                  8'({$urandom_range(0, 3), $urandom_range(0, 3)}) & 8'h33,
                  4'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
        end

        repeat (2) @(negedge clk);
        chk("sb_drain", cyc, 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised forwarding and hazard-control unit for the pipelined core, sitting between the ID/EX, EX/MEM and MEM/WB pipeline registers and the pipeline-control logic. It selects ALU operand forwarding for NSRC source operands with EX/MEM-over-MEM/WB priority. It detects load-use hazards and holds a stall for a programmable number of cycles through a small state machine, applies branch flushes, and keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- REG_W, 4, register-index width (2^REG_W architectural registers; index 0 is hard-wired zero)
- NSRC, 2, number of source operands per instruction
- LOAD_LAT, 1, stall cycles per load-use hazard (≥1)
- CNT_W, 16, stall-counter width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- id_src  in  NSRC*REG_W  source indices of instruction in ID (operand i at bits [i*REG_W +: REG_W])
- id_src_use  in  NSRC  operand i actually read by ID instruction
- ex_src  in  NSRC*REG_W  source indices of instruction in EX (ID/EX register)
- ex_rd, ex_rw, ex_load  in  REG_W,1,1  ID/EX destination, write enable, is-load
- mem_rd, mem_rw  in  REG_W,1  EX/MEM destination, write enable
- wb_rd, wb_rw  in  REG_W,1  MEM/WB destination, write enable
- br_taken  in  1  branch resolved taken in EX this cycle
- fwd_sel  out  2*NSRC  per-operand mux select: 00 register file, 10 EX/MEM, 01 MEM/WB
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
- flush  out  1  squash IF/ID and ID/EX
- stall_cnt  out  CNT_W  total stall cycles since reset, saturating

## Operation
- Forwarding (combinational, per operand i):
  - 10 if mem_rw & mem_rd≠0 & mem_rd==ex_src[i].
  - Else 01 if wb_rw & wb_rd≠0 & wb_rd==ex_src[i].
  - Else 00.
  - EX/MEM always wins when both match.
- Load-use hit: ex_load & ex_rw & ex_rd≠0 & ∃i: id_src_use[i] & id_src[i]==ex_rd.
- FSM states RUN, HOLD; down-counter rem (width ≥ clog2(LOAD_LAT)+1).
  - RUN, no hit: stall=0.
  - RUN, hit & !br_taken: stall=1 this cycle. If LOAD_LAT>1, next state HOLD with rem=LOAD_LAT-1; else stay RUN.
  - HOLD: stall=1 regardless of inputs, rem decrements each cycle. Return to RUN on the cycle rem==1, so the stall covers exactly LOAD_LAT cycles in total.
- Branch:
  - flush=br_taken (combinational).
  - br_taken forces stall=0 and next state RUN, in either state; the dependent instruction is squashed, so the hazard is void.
- stall_cnt increments on every clock edge where stall=1 and rst=0. It holds at 2^CNT_W−1.
- Register 0 never forwards and never causes a stall.
- Reset (rst=1 at edge): state RUN, rem 0, stall_cnt 0. While rst is high, stall=0, flush=0, fwd_sel=0.

## Timing
- fwd_sel, flush: zero-cycle combinational from inputs.
- stall: combinational in the first hazard cycle; registered (from state) for the remaining LOAD_LAT−1 cycles.
- Pipeline contract: during a stall the ID/EX bubble clears ex_load/ex_rw next cycle, so RUN does not re-trigger on the same load.
- A new hazard arriving on the cycle HOLD exits to RUN is evaluated in RUN on the following cycle.
- Reset mid-HOLD: the next cycle is RUN with stall=0; stall_cnt reads 0.
- stall_cnt reflects stall cycles up to and including the previous edge.

## Test plan
- EX/MEM forward, operand 0: mem_rw=1, mem_rd=3, ex_src0=3, wb_rw=1, wb_rd=3 -> fwd_sel[1:0]=10 (priority). Repeat with mem_rw=0 -> 01. Repeat with mem_rd=wb_rd=0 -> 00.
- Load-use, LOAD_LAT=1: ex_load=1, ex_rw=1, ex_rd=5, id_src1=5, id_src_use=2'b10 -> stall=1 for 1 cycle, then 0 after the bubble; stall_cnt=1. With id_src_use=2'b00 -> no stall.
- Load-use, LOAD_LAT=3: same stimulus, inputs cleared after first cycle -> stall high exactly 3 consecutive cycles; stall_cnt=3.
- Branch during HOLD, LOAD_LAT=3: br_taken=1 in second stall cycle -> flush=1, stall=0 that cycle, FSM RUN next; stall_cnt=1.
- Reset mid-HOLD and saturation: rst in HOLD -> stall=0, stall_cnt=0 next cycle. With CNT_W=2, 5 stall cycles -> stall_cnt sticks at 3.
